hsstl_phy_mac_rdata_proc_mx: RTL and testbench
==============================================

// Module: hsstl_phy_mac_rdata_proc_mx
// PURPOSE
//  Multi-lane, width-parametrised receive datapath between the HSST PCS and the PIPE MAC.
//  Per lane it:
//   - unpacks PCS symbols into rxdata/rxdatak;
//   - substitutes EDB (K30.7) on decode error or CTC underflow;
//   - encodes PIPE rxstatus with a fixed priority;
//   - optionally rewrites continuous-SKP-delete patterns, including patterns that span two pclk beats.
//  Adds saturating per-lane decode/disparity error counters for the LTSSM/debug register file.
// PARAMETERS
//  NUM_LANES            1  lanes, 1..8
//  SYMS                 4  symbols per lane per pclk: 2 or 4
//  EN_CONTI_SKP_REPLACE 0  1 = enable continuous-SKP-delete rewrite
//  ERR_CNT_W            8  error counter width, 2..16
// PORTS  (LW = 11*SYMS+3; lane n occupies slice n of every bus)
//  pclk             in   1               PIPE clock; all logic on rising edge
//  rst              in   1               synchronous, active-high reset
//  P_RDATA          in   NUM_LANES*LW    per lane: symbol s = bits [11s+10:11s]
//                                        ({K, decode_err, disp_err, data[7:0]}); [LW-1:LW-3] = PCS status
//  rx_det_done      in   NUM_LANES       receiver-detect complete, per lane
//  lx_rxdct_out_d   in   NUM_LANES       receiver-detect result, per lane
//  err_cnt_clr      in   1               clears all error counters
//  phy_mac_rxdata   out  NUM_LANES*8*SYMS  symbol s of lane n at bits [8s+7:8s] of the lane slice
//  phy_mac_rxdatak  out  NUM_LANES*SYMS    K flag per symbol
//  phy_mac_rxstatus out  NUM_LANES*3       PIPE RxStatus
//  dec_err_cnt      out  NUM_LANES*ERR_CNT_W  saturating decode-error count
//  disp_err_cnt     out  NUM_LANES*ERR_CNT_W  saturating disparity-error count
// BEHAVIOUR
//  Reset and latency
//  - rst=1: all outputs 0, SKP FSM in IDLE.
//  - All outputs are registered: 1 pclk latency, no bubbles, no handshake.
//  Status (st = lane PCS status). Priority, highest first:
//   1. rx_det_done      -> {0, det, det}
//   2. any decode_err   -> 100
//   3. st = 100 or 101  -> 101 (overflow)
//   4. st = 110 or 111  -> 110 (underflow)
//   5. any disp_err     -> 111
//   6. otherwise        -> st
//  Data per symbol
//  - underflow (st[2:1] = 11) or decode_err of that symbol -> {K=1, FE}.
//  - else if the SKP rewrite fires -> forced value (see below).
//  - else -> {K, data}.
//  SKP rewrite (EN_CONTI_SKP_REPLACE = 1 only)
//  - "clean" = no decode or disparity error on any symbol of the lane this beat.
//  - COM = {K=1, BC}; SKP = {K=1, 1C}.
//  - SYMS = 4, in-beat:
//    - clean, st = 011, and symbols 0..3 = COM, SKP, SKP, COM
//      -> output symbol 2 = COM, symbol 3 = SKP; symbols 0 and 1 unchanged.
//  - SYMS = 2, per-lane FSM:
//    - IDLE -> ARM when the beat is clean and symbols 0..1 = COM, SKP.
//    - ARM:
//      - beat clean, st = 011, symbols = SKP, COM
//        -> output symbol 0 = COM, symbol 1 = SKP; next state IDLE.
//      - beat is COM, SKP again -> stay ARM.
//      - any other beat -> IDLE.
//    - Decode error or underflow while in ARM -> IDLE.
//    - EDB substitution always beats the rewrite.
//    - rst mid-pattern -> IDLE; the following beat is never rewritten.
//  Counters (per lane)
//  - Each beat adds the number of symbols with decode_err (dec) or disp_err (disp) to the
//    respective counter, 0..SYMS per beat.
//  - Counters saturate at all-ones and never wrap.
//  - err_cnt_clr forces 0 and wins over a same-cycle increment; that beat's errors are discarded.
//  - rx_det_done does not affect the counters.
//  Lane independence
//  - Lanes are fully independent; one lane's errors or FSM state never affect another lane.
// TESTING
//  1. NUM_LANES=4, SYMS=4: clean data 0x11..0x44, st=000 on all lanes
//     -> same data 1 cycle later, K=0, status 000.
//  2. Lane 1: decode_err on symbol 2 and st=101 in the same beat
//     -> status 100; symbol 2 = K/FE; other symbols pass through; dec_err_cnt[1] += 1.
//  3. EN_CONTI_SKP_REPLACE=1, SYMS=4: COM,SKP,SKP,COM with st=011 -> COM,SKP,COM,SKP, status 011.
//     Repeat with one disp_err -> data unchanged, status 111.
//  4. SYMS=2: beat COM,SKP then beat SKP,COM (st=011) -> second output COM,SKP.
//     Insert an idle beat between the two -> no rewrite.
//     Assert rst in ARM -> no rewrite.
//  5. ERR_CNT_W=2: 5 beats with 1 decode error each -> dec_err_cnt = 3 (saturated).
//     Pulse err_cnt_clr on an erroring beat -> 0.
//  6. rx_det_done with lx_rxdct_out_d=1, st=110 -> status 011.
//     Next beat, st=110 -> status 110; all symbols = K/FE.

Source files
------------

// File: rtl/hsstl_phy_mac_rdata_proc_mx_if.sv
`default_nettype none
//==============================================================================
// Module      : hsstl_phy_mac_rdata_proc_mx_if
// Description : PCS-to-MAC receive bus bundle: packed per-lane PCS symbols and
//               receiver-detect inputs, PIPE rx data/status and error counters.
// Revision    : 1.0 - initial release
//==============================================================================
interface hsstl_phy_mac_rdata_proc_mx_if #(
  parameter int NUM_LANES = 1,
  parameter int SYMS      = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int LW = 11 * SYMS + 3;

  logic [NUM_LANES*LW-1:0]        P_RDATA;
  logic [NUM_LANES-1:0]           rx_det_done;
  logic [NUM_LANES-1:0]           lx_rxdct_out_d;
  logic                           err_cnt_clr;
  logic [NUM_LANES*8*SYMS-1:0]    phy_mac_rxdata;
  logic [NUM_LANES*SYMS-1:0]      phy_mac_rxdatak;
  logic [NUM_LANES*3-1:0]         phy_mac_rxstatus;
  logic [NUM_LANES*ERR_CNT_W-1:0] dec_err_cnt;
  logic [NUM_LANES*ERR_CNT_W-1:0] disp_err_cnt;

  // PCS / register-file side: drives symbols and control, observes results
  modport master (
    output P_RDATA, rx_det_done, lx_rxdct_out_d, err_cnt_clr,
    input  phy_mac_rxdata, phy_mac_rxdatak, phy_mac_rxstatus,
           dec_err_cnt, disp_err_cnt
  );

  // Receive datapath side
  modport slave (
    input  P_RDATA, rx_det_done, lx_rxdct_out_d, err_cnt_clr,
    output phy_mac_rxdata, phy_mac_rxdatak, phy_mac_rxstatus,
           dec_err_cnt, disp_err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hsstl_phy_mac_rdata_proc_mx.sv
`default_nettype none
//==============================================================================
// Module      : hsstl_phy_mac_rdata_proc_mx
// Description : Multi-lane PCS-to-PIPE receive datapath. Unpacks symbols,
//               substitutes EDB on decode error / CTC underflow, encodes
//               RxStatus, optionally rewrites continuous-SKP-delete patterns
//               and keeps saturating per-lane decode/disparity error counters.
// Revision    : 1.0 - initial release
//==============================================================================
module hsstl_phy_mac_rdata_proc_mx #(
  parameter int NUM_LANES            = 1,
  parameter int SYMS                 = 4,
  parameter int EN_CONTI_SKP_REPLACE = 0,
  parameter int ERR_CNT_W            = 8
) (
  input  wire logic                     pclk,
  input  wire logic                     rst,
  hsstl_phy_mac_rdata_proc_mx_if.slave  bus
);

  localparam int         LW      = 11 * SYMS + 3;
  // {K, data} encodings of the ordered-set symbols handled here
  localparam logic [8:0] COM_SYM = 9'h1BC;
  localparam logic [8:0] SKP_SYM = 9'h11C;
  localparam logic [8:0] EDB_SYM = 9'h1FE;

  typedef enum logic [0:0] {
    SKP_IDLE = 1'b0,
    SKP_ARM  = 1'b1
  } skp_state_t;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    logic [10:0]          sym [SYMS];   // {K, decode_err, disp_err, data}
    logic [8:0]           val [SYMS];   // outgoing {K, data}
    logic [2:0]           st;
    logic                 any_dec;
    logic                 any_disp;
    logic                 underflow;
    logic                 fire;         // SKP rewrite applies to this beat
    logic [ERR_CNT_W:0]   dec_num;
    logic [ERR_CNT_W:0]   disp_num;
    logic [ERR_CNT_W:0]   dec_sum;
    logic [ERR_CNT_W:0]   disp_sum;
    logic [2:0]           status_d;
    logic [8*SYMS-1:0]    rxdata_d;
    logic [SYMS-1:0]      rxdatak_d;
    logic [8*SYMS-1:0]    rxdata_q;
    logic [SYMS-1:0]      rxdatak_q;
    logic [2:0]           status_q;
    logic [ERR_CNT_W-1:0] dec_cnt_q;
    logic [ERR_CNT_W-1:0] disp_cnt_q;

    assign st        = bus.P_RDATA[n*LW + LW-3 +: 3];
    assign underflow = (st[2:1] == 2'b11);

    // Split the lane slice into symbols and tally this beat's error flags
    always_comb begin
      any_dec  = 1'b0;
      any_disp = 1'b0;
      dec_num  = '0;
      disp_num = '0;
      for (int s = 0; s < SYMS; s++) begin
        sym[s]   = bus.P_RDATA[n*LW + 11*s +: 11];
        any_dec  = any_dec  | sym[s][9];
        any_disp = any_disp | sym[s][8];
        dec_num  = dec_num  + {{ERR_CNT_W{1'b0}}, sym[s][9]};
        disp_num = disp_num + {{ERR_CNT_W{1'b0}}, sym[s][8]};
      end
    end

    // RxStatus with receiver-detect highest and disparity lowest priority
    always_comb begin
      status_d = st;
      if (bus.rx_det_done[n]) begin
        status_d = {1'b0, bus.lx_rxdct_out_d[n], bus.lx_rxdct_out_d[n]};
      end else if (any_dec) begin
        status_d = 3'b100;
      end else if (st[2:1] == 2'b10) begin
        status_d = 3'b101;
      end else if (underflow) begin
        status_d = 3'b110;
      end else if (any_disp) begin
        status_d = 3'b111;
      end
    end

    // Symbol mux: the rewrite always lands on the last two symbols of the beat,
    // and EDB substitution overrides everything else
    always_comb begin
      rxdata_d  = '0;
      rxdatak_d = '0;
      for (int s = 0; s < SYMS; s++) begin
        val[s] = {sym[s][10], sym[s][7:0]};
        if (fire && (s == SYMS-2)) val[s] = COM_SYM;
        if (fire && (s == SYMS-1)) val[s] = SKP_SYM;
        if (underflow || sym[s][9]) val[s] = EDB_SYM;
        rxdata_d[8*s +: 8] = val[s][7:0];
        rxdatak_d[s]       = val[s][8];
      end
    end

    if ((EN_CONTI_SKP_REPLACE != 0) && (SYMS == 4)) begin : g_skp4
      logic clean;
      assign clean = !any_dec && !any_disp;
      assign fire  = clean && (st == 3'b011) &&
                     ({sym[0][10], sym[0][7:0]} == COM_SYM) &&
                     ({sym[1][10], sym[1][7:0]} == SKP_SYM) &&
                     ({sym[2][10], sym[2][7:0]} == SKP_SYM) &&
                     ({sym[3][10], sym[3][7:0]} == COM_SYM);
    end else if ((EN_CONTI_SKP_REPLACE != 0) && (SYMS == 2)) begin : g_skp2
      skp_state_t state_q;
      skp_state_t state_d;
      logic       clean;
      logic       pair_com_skp;
      logic       pair_skp_com;

      assign clean        = !any_dec && !any_disp;
      assign pair_com_skp = clean &&
                            ({sym[0][10], sym[0][7:0]} == COM_SYM) &&
                            ({sym[1][10], sym[1][7:0]} == SKP_SYM);
      assign pair_skp_com = clean &&
                            ({sym[0][10], sym[0][7:0]} == SKP_SYM) &&
                            ({sym[1][10], sym[1][7:0]} == COM_SYM);

      // Pattern tracker state register
      always_ff @(posedge pclk) begin
        if (rst) begin
          state_q <= SKP_IDLE;
        end else begin
          state_q <= state_d;
        end
      end

      // Cross-beat COM,SKP | SKP,COM detection
      always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
          SKP_IDLE: begin
            if (pair_com_skp) state_d = SKP_ARM;
          end
          SKP_ARM: begin
            if (any_dec || underflow) begin
              state_d = SKP_IDLE;
            end else if (pair_skp_com && (st == 3'b011)) begin
              fire    = 1'b1;
              state_d = SKP_IDLE;
            end else if (pair_com_skp) begin
              state_d = SKP_ARM;
            end else begin
              state_d = SKP_IDLE;
            end
          end
          default: state_d = SKP_IDLE;
        endcase
      end
    end else begin : g_skp_off
      assign fire = 1'b0;
    end

    assign dec_sum  = {1'b0, dec_cnt_q}  + dec_num;
    assign disp_sum = {1'b0, disp_cnt_q} + disp_num;

    // Output registers and saturating error counters
    always_ff @(posedge pclk) begin
      if (rst) begin
        rxdata_q   <= '0;
        rxdatak_q  <= '0;
        status_q   <= '0;
        dec_cnt_q  <= '0;
        disp_cnt_q <= '0;
      end else begin
        rxdata_q  <= rxdata_d;
        rxdatak_q <= rxdatak_d;
        status_q  <= status_d;
        if (bus.err_cnt_clr) begin
          dec_cnt_q  <= '0;
          disp_cnt_q <= '0;
        end else begin
          dec_cnt_q  <= dec_sum[ERR_CNT_W]  ? '1 : dec_sum[ERR_CNT_W-1:0];
          disp_cnt_q <= disp_sum[ERR_CNT_W] ? '1 : disp_sum[ERR_CNT_W-1:0];
        end
      end
    end

    assign bus.phy_mac_rxdata[n*8*SYMS +: 8*SYMS]       = rxdata_q;
    assign bus.phy_mac_rxdatak[n*SYMS +: SYMS]          = rxdatak_q;
    assign bus.phy_mac_rxstatus[n*3 +: 3]               = status_q;
    assign bus.dec_err_cnt[n*ERR_CNT_W +: ERR_CNT_W]    = dec_cnt_q;
    assign bus.disp_err_cnt[n*ERR_CNT_W +: ERR_CNT_W]   = disp_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_hsstl_phy_mac_rdata_proc_mx.sv
`default_nettype none
//==============================================================================
// Module      : tb_hsstl_phy_mac_rdata_proc_mx
// Description : Bench for three configurations of the receive datapath
//               (4x4 with in-beat SKP rewrite, 2x2 with cross-beat rewrite and
//               2-bit counters, 1x4 with rewrite disabled).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_hsstl_phy_mac_rdata_proc_mx;

  localparam logic [8:0] COM = 9'h1BC;
  localparam logic [8:0] SKP = 9'h11C;
  localparam logic [8:0] EDB = 9'h1FE;
  localparam int NDUT = 3;
  localparam int ML   = 4;
  localparam int MS   = 4;
  localparam int LW_A = 47;
  localparam int LW_B = 25;
  localparam int LW_C = 47;

  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  hsstl_phy_mac_rdata_proc_mx_if #(.NUM_LANES(4), .SYMS(4), .ERR_CNT_W(8)) bus_a ();
  hsstl_phy_mac_rdata_proc_mx_if #(.NUM_LANES(2), .SYMS(2), .ERR_CNT_W(2)) bus_b ();
  hsstl_phy_mac_rdata_proc_mx_if #(.NUM_LANES(1), .SYMS(4), .ERR_CNT_W(3)) bus_c ();

  hsstl_phy_mac_rdata_proc_mx #(.NUM_LANES(4), .SYMS(4), .EN_CONTI_SKP_REPLACE(1), .ERR_CNT_W(8))
    dut_a (.pclk(pclk), .rst(rst), .bus(bus_a));
  hsstl_phy_mac_rdata_proc_mx #(.NUM_LANES(2), .SYMS(2), .EN_CONTI_SKP_REPLACE(1), .ERR_CNT_W(2))
    dut_b (.pclk(pclk), .rst(rst), .bus(bus_b));
  hsstl_phy_mac_rdata_proc_mx #(.NUM_LANES(1), .SYMS(4), .EN_CONTI_SKP_REPLACE(0), .ERR_CNT_W(3))
    dut_c (.pclk(pclk), .rst(rst), .bus(bus_c));

  // Stimulus fields, per DUT / lane / symbol
  logic       in_k    [NDUT][ML][MS];
  logic       in_dec  [NDUT][ML][MS];
  logic       in_disp [NDUT][ML][MS];
  logic [7:0] in_data [NDUT][ML][MS];
  logic [2:0] in_st   [NDUT][ML];
  logic       in_det  [NDUT][ML];
  logic       in_res  [NDUT][ML];
  logic       in_clr  [NDUT];

  // Reference expectations
  logic [8:0] ex_sym  [NDUT][ML][MS];
  logic [2:0] ex_stat [NDUT][ML];
  int         ex_dec  [NDUT][ML];
  int         ex_disp [NDUT][ML];
  bit         armed   [NDUT][ML];   // previous beat was a clean COM,SKP pair

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int nl_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 1;
  endfunction
  function automatic int ns_of(input int d);
    return (d == 1) ? 2 : 4;
  endfunction
  function automatic int w_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 2 : 3;
  endfunction
  function automatic bit en_of(input int d);
    return (d != 2);
  endfunction

  // Pack stimulus fields onto each bus
  always_comb begin
    bus_a.P_RDATA = '0; bus_a.rx_det_done = '0; bus_a.lx_rxdct_out_d = '0;
    for (int l = 0; l < 4; l++) begin
      for (int s = 0; s < 4; s++)
        bus_a.P_RDATA[l*LW_A + 11*s +: 11] = {in_k[0][l][s], in_dec[0][l][s], in_disp[0][l][s], in_data[0][l][s]};
      bus_a.P_RDATA[l*LW_A + LW_A-3 +: 3] = in_st[0][l];
      bus_a.rx_det_done[l]    = in_det[0][l];
      bus_a.lx_rxdct_out_d[l] = in_res[0][l];
    end
    bus_a.err_cnt_clr = in_clr[0];
  end

  always_comb begin
    bus_b.P_RDATA = '0; bus_b.rx_det_done = '0; bus_b.lx_rxdct_out_d = '0;
    for (int l = 0; l < 2; l++) begin
      for (int s = 0; s < 2; s++)
        bus_b.P_RDATA[l*LW_B + 11*s +: 11] = {in_k[1][l][s], in_dec[1][l][s], in_disp[1][l][s], in_data[1][l][s]};
      bus_b.P_RDATA[l*LW_B + LW_B-3 +: 3] = in_st[1][l];
      bus_b.rx_det_done[l]    = in_det[1][l];
      bus_b.lx_rxdct_out_d[l] = in_res[1][l];
    end
    bus_b.err_cnt_clr = in_clr[1];
  end

  always_comb begin
    bus_c.P_RDATA = '0; bus_c.rx_det_done = '0; bus_c.lx_rxdct_out_d = '0;
    for (int s = 0; s < 4; s++)
      bus_c.P_RDATA[11*s +: 11] = {in_k[2][0][s], in_dec[2][0][s], in_disp[2][0][s], in_data[2][0][s]};
    bus_c.P_RDATA[LW_C-3 +: 3] = in_st[2][0];
    bus_c.rx_det_done[0]    = in_det[2][0];
    bus_c.lx_rxdct_out_d[0] = in_res[2][0];
    bus_c.err_cnt_clr = in_clr[2];
  end

  function automatic logic [8:0] obs_sym(input int d, input int l, input int s);
    case (d)
      0:       return {bus_a.phy_mac_rxdatak[l*4+s], bus_a.phy_mac_rxdata[(l*4+s)*8 +: 8]};
      1:       return {bus_b.phy_mac_rxdatak[l*2+s], bus_b.phy_mac_rxdata[(l*2+s)*8 +: 8]};
      default: return {bus_c.phy_mac_rxdatak[s],     bus_c.phy_mac_rxdata[s*8 +: 8]};
    endcase
  endfunction

  function automatic logic [2:0] obs_stat(input int d, input int l);
    case (d)
      0:       return bus_a.phy_mac_rxstatus[l*3 +: 3];
      1:       return bus_b.phy_mac_rxstatus[l*3 +: 3];
      default: return bus_c.phy_mac_rxstatus[2:0];
    endcase
  endfunction

  function automatic int obs_cnt(input int d, input int l, input bit disp);
    case (d)
      0:       return disp ? int'(bus_a.disp_err_cnt[l*8 +: 8]) : int'(bus_a.dec_err_cnt[l*8 +: 8]);
      1:       return disp ? int'(bus_b.disp_err_cnt[l*2 +: 2]) : int'(bus_b.dec_err_cnt[l*2 +: 2]);
      default: return disp ? int'(bus_c.disp_err_cnt[2:0])    : int'(bus_c.dec_err_cnt[2:0]);
    endcase
  endfunction

  task automatic cmp(input string tag, input int d, input int l, input int s,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d lane%0d sym%0d: observed %h expected %h", tag, d, l, s, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < NDUT; d++) begin
      in_clr[d] = 1'b0;
      for (int l = 0; l < ML; l++) begin
        in_st[d][l] = 3'b000; in_det[d][l] = 1'b0; in_res[d][l] = 1'b0;
        for (int s = 0; s < MS; s++) begin
          in_k[d][l][s] = 1'b0; in_dec[d][l][s] = 1'b0;
          in_disp[d][l][s] = 1'b0; in_data[d][l][s] = 8'h00;
        end
      end
    end
  endtask

  task automatic set_sym(input int d, input int l, input int s, input logic [8:0] v);
    in_k[d][l][s]    = v[8];
    in_data[d][l][s] = v[7:0];
  endtask

  // Expected outputs after the next edge, from the current inputs
  task automatic model_beat(input int d);
    int nl, ns, mx, ndec, ndisp;
    bit en, uf, clean, rw, com_skp;
    logic [8:0] v [MS];
    logic [8:0] e;
    logic [2:0] st;
    nl = nl_of(d); ns = ns_of(d); en = en_of(d); mx = (1 << w_of(d)) - 1;
    for (int l = 0; l < nl; l++) begin
      if (rst) begin
        for (int s = 0; s < MS; s++) ex_sym[d][l][s] = 9'h000;
        ex_stat[d][l] = 3'b000; ex_dec[d][l] = 0; ex_disp[d][l] = 0; armed[d][l] = 1'b0;
      end else begin
        ndec = 0; ndisp = 0;
        for (int s = 0; s < MS; s++) begin
          v[s] = {in_k[d][l][s], in_data[d][l][s]};
          if (s < ns) begin
            ndec  += int'(in_dec[d][l][s]);
            ndisp += int'(in_disp[d][l][s]);
          end
        end
        st    = in_st[d][l];
        uf    = (st == 3'd6) || (st == 3'd7);
        clean = (ndec == 0) && (ndisp == 0);
        if (in_det[d][l])                    ex_stat[d][l] = {1'b0, in_res[d][l], in_res[d][l]};
        else if (ndec > 0)                   ex_stat[d][l] = 3'd4;
        else if (st == 3'd4 || st == 3'd5)   ex_stat[d][l] = 3'd5;
        else if (uf)                         ex_stat[d][l] = 3'd6;
        else if (ndisp > 0)                  ex_stat[d][l] = 3'd7;
        else                                 ex_stat[d][l] = st;
        rw = 1'b0;
        if (en && clean && st == 3'd3) begin
          if (ns == 4) rw = (v[0] == COM) && (v[1] == SKP) && (v[2] == SKP) && (v[3] == COM);
          else         rw = armed[d][l] && (v[0] == SKP) && (v[1] == COM);
        end
        com_skp = clean && (v[0] == COM) && (v[1] == SKP);
        armed[d][l] = en && (ns == 2) && com_skp && !(armed[d][l] && uf);
        for (int s = 0; s < ns; s++) begin
          e = v[s];
          if (rw && s == ns-2) e = COM;
          if (rw && s == ns-1) e = SKP;
          if (uf || in_dec[d][l][s]) e = EDB;
          ex_sym[d][l][s] = e;
        end
        if (in_clr[d]) begin
          ex_dec[d][l] = 0; ex_disp[d][l] = 0;
        end else begin
          ex_dec[d][l]  = (ex_dec[d][l]  + ndec  > mx) ? mx : ex_dec[d][l]  + ndec;
          ex_disp[d][l] = (ex_disp[d][l] + ndisp > mx) ? mx : ex_disp[d][l] + ndisp;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < NDUT; d++) begin
      for (int l = 0; l < nl_of(d); l++) begin
        for (int s = 0; s < ns_of(d); s++)
          cmp("model_sym", d, l, s, 32'(obs_sym(d, l, s)), 32'(ex_sym[d][l][s]));
        cmp("model_status",   d, l, 0, 32'(obs_stat(d, l)), 32'(ex_stat[d][l]));
        cmp("model_dec_cnt",  d, l, 0, obs_cnt(d, l, 1'b0), ex_dec[d][l]);
        cmp("model_disp_cnt", d, l, 0, obs_cnt(d, l, 1'b1), ex_disp[d][l]);
      end
    end
  endtask

  task automatic step();
    for (int d = 0; d < NDUT; d++) model_beat(d);
    @(posedge pclk);
    #1;
    check_all();
  endtask

  task automatic rand_beat();
    int r;
    for (int d = 0; d < NDUT; d++) begin
      in_clr[d] = ($urandom_range(0, 39) == 0);
      for (int l = 0; l < ML; l++) begin
        r = $urandom_range(0, 7);
        in_st[d][l]  = (r < 4) ? 3'b011 : (r == 4) ? 3'b000 : 3'($urandom);
        in_det[d][l] = ($urandom_range(0, 31) == 0);
        in_res[d][l] = 1'($urandom_range(0, 1));
        for (int s = 0; s < MS; s++) begin
          r = $urandom_range(0, 2);
          set_sym(d, l, s, (r == 0) ? COM : (r == 1) ? SKP : {1'($urandom_range(0, 1)), 8'($urandom)});
          in_dec[d][l][s]  = ($urandom_range(0, 15) == 0);
          in_disp[d][l][s] = ($urandom_range(0, 15) == 0);
        end
      end
    end
  endtask

  initial begin
    // Reset: every output zero
    rst = 1'b1;
    idle_all();
    step();
    step();
    cmp("reset_status", 0, 3, 0, 32'(obs_stat(0, 3)), 32'd0);
    rst = 1'b0;

    // Clean pass-through on all lanes of the 4x4 instance
    idle_all();
    for (int l = 0; l < 4; l++)
      for (int s = 0; s < 4; s++) in_data[0][l][s] = 8'(8'h11 * (s + 1));
    step();
    cmp("pass_sym3", 0, 2, 3, 32'(obs_sym(0, 2, 3)), 32'h044);
    cmp("pass_status", 0, 2, 0, 32'(obs_status_wrap(0, 2)), 32'd0);

    // Decode error on lane 1 symbol 2 with overflow status: decode error wins
    idle_all();
    for (int s = 0; s < 4; s++) in_data[0][1][s] = 8'(8'h11 * (s + 1));
    in_dec[0][1][2] = 1'b1;
    in_st[0][1]     = 3'b101;
    step();
    cmp("dec_status", 0, 1, 0, 32'(obs_stat(0, 1)), 32'd4);
    cmp("dec_edb",    0, 1, 2, 32'(obs_sym(0, 1, 2)), 32'(EDB));
    cmp("dec_pass",   0, 1, 1, 32'(obs_sym(0, 1, 1)), 32'h022);
    cmp("dec_cnt",    0, 1, 0, obs_cnt(0, 1, 1'b0), 1);

    // In-beat COM,SKP,SKP,COM rewrite; disabled instance leaves it alone
    idle_all();
    for (int d = 0; d < 3; d += 2) begin
      set_sym(d, 0, 0, COM); set_sym(d, 0, 1, SKP); set_sym(d, 0, 2, SKP); set_sym(d, 0, 3, COM);
      in_st[d][0] = 3'b011;
    end
    step();
    cmp("skp4_sym2", 0, 0, 2, 32'(obs_sym(0, 0, 2)), 32'(COM));
    cmp("skp4_sym3", 0, 0, 3, 32'(obs_sym(0, 0, 3)), 32'(SKP));
    cmp("skp4_status", 0, 0, 0, 32'(obs_stat(0, 0)), 32'd3);
    cmp("skp4_off_sym2", 2, 0, 2, 32'(obs_sym(2, 0, 2)), 32'(SKP));
    in_disp[0][0][1] = 1'b1;
    step();
    cmp("skp4_disp_sym2", 0, 0, 2, 32'(obs_sym(0, 0, 2)), 32'(SKP));
    cmp("skp4_disp_status", 0, 0, 0, 32'(obs_stat(0, 0)), 32'd7);

    // Cross-beat rewrite on the 2-symbol instance
    idle_all(); set_sym(1, 0, 0, COM); set_sym(1, 0, 1, SKP); step();
    idle_all(); set_sym(1, 0, 0, SKP); set_sym(1, 0, 1, COM); in_st[1][0] = 3'b011; step();
    cmp("skp2_sym0", 1, 0, 0, 32'(obs_sym(1, 0, 0)), 32'(COM));
    cmp("skp2_sym1", 1, 0, 1, 32'(obs_sym(1, 0, 1)), 32'(SKP));
    // Idle beat between the halves breaks the pattern
    idle_all(); set_sym(1, 0, 0, COM); set_sym(1, 0, 1, SKP); step();
    idle_all(); step();
    set_sym(1, 0, 0, SKP); set_sym(1, 0, 1, COM); in_st[1][0] = 3'b011; step();
    cmp("skp2_gap_sym0", 1, 0, 0, 32'(obs_sym(1, 0, 0)), 32'(SKP));
    // Reset while armed
    idle_all(); set_sym(1, 0, 0, COM); set_sym(1, 0, 1, SKP); step();
    rst = 1'b1; idle_all(); step(); rst = 1'b0;
    set_sym(1, 0, 0, SKP); set_sym(1, 0, 1, COM); in_st[1][0] = 3'b011; step();
    cmp("skp2_rst_sym0", 1, 0, 0, 32'(obs_sym(1, 0, 0)), 32'(SKP));

    // 2-bit counter saturation, then clear on an erroring beat
    idle_all();
    in_dec[1][0][0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    cmp("sat_dec_cnt", 1, 0, 0, obs_cnt(1, 0, 1'b0), 3);
    in_clr[1] = 1'b1;
    step();
    cmp("clr_dec_cnt", 1, 0, 0, obs_cnt(1, 0, 1'b0), 0);

    // Receiver detect beats underflow; underflow alone gives EDB everywhere
    idle_all();
    in_det[0][2] = 1'b1; in_res[0][2] = 1'b1; in_st[0][2] = 3'b110;
    step();
    cmp("det_status", 0, 2, 0, 32'(obs_stat(0, 2)), 32'd3);
    idle_all();
    in_st[0][2] = 3'b110;
    step();
    cmp("uf_status", 0, 2, 0, 32'(obs_stat(0, 2)), 32'd6);
    for (int s = 0; s < 4; s++) cmp("uf_edb", 0, 2, s, 32'(obs_sym(0, 2, s)), 32'(EDB));

    // Randomised traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      rand_beat();
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic [2:0] obs_status_wrap(input int d, input int l);
    return obs_stat(d, l);
  endfunction

endmodule
`default_nettype wire
